// File: rtl/write_dest_tracker_pkg.sv
// Opcode, funct and REGIMM-rt encodings of the MIPS-I subset the destination
// tracker recognises, with small opcode-class helpers.
package write_dest_tracker_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;
    localparam logic [5:0] OP_ADDI    = 6'd8;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_SLTI    = 6'd10;
    localparam logic [5:0] OP_SLTIU   = 6'd11;
    localparam logic [5:0] OP_ANDI    = 6'd12;
    localparam logic [5:0] OP_ORI     = 6'd13;
    localparam logic [5:0] OP_XORI    = 6'd14;
    localparam logic [5:0] OP_LUI     = 6'd15;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_SRLV  = 6'd6;
    localparam logic [5:0] FN_SRAV  = 6'd7;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_JALR  = 6'd9;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;
    localparam logic [4:0] RT_BLTZAL = 5'd16;
    localparam logic [4:0] RT_BGEZAL = 5'd17;

    localparam logic [4:0] REG_RA = 5'd31;
    localparam int         CNT_W  = 4;

    // LB LH LWL LW LBU LHU LWR
    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38};
    endfunction

    // SB SH SWL SW SWR
    function automatic logic is_store_op(input logic [5:0] op);
        return op inside {6'd40, 6'd41, 6'd42, 6'd43, 6'd46};
    endfunction

endpackage

// File: rtl/write_dest_tracker_dest_decode.sv
// Combinational decode of destination register, load flag, LO/HI access and
// source-register use for one instruction word.
module dest_decode
    import write_dest_tracker_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [4:0]  dest,
    output logic        is_load,
    output logic        lohi_wr,
    output logic        lohi_rd,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        illegal
);
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    logic       unused_shamt;

    assign op = instruction[31:26];
    assign rt = instruction[20:16];
    assign rd = instruction[15:11];
    assign fn = instruction[5:0];
    assign unused_shamt = ^instruction[10:6];

    always_comb begin
        dest    = 5'd0;
        is_load = 1'b0;
        lohi_wr = 1'b0;
        lohi_rd = 1'b0;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_SPECIAL: begin
                uses_rt = 1'b1;
                dest    = rd;
                case (fn)
                    FN_JR:             dest = 5'd0;
                    FN_MULT, FN_MULTU: lohi_wr = 1'b1;
                    FN_MFHI, FN_MFLO:  lohi_rd = 1'b1;
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_JALR, FN_MTHI, FN_MTLO, FN_DIV, FN_DIVU,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ;
                    default:           illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ:     ;
                    RT_BLTZAL, RT_BGEZAL: dest = REG_RA;
                    default:              illegal = 1'b1;
                endcase
            end
            OP_J:   uses_rs = 1'b0;
            OP_JAL: begin
                uses_rs = 1'b0;
                dest    = REG_RA;
            end
            OP_BEQ, OP_BNE:   uses_rt = 1'b1;
            OP_BLEZ, OP_BGTZ: ;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
                dest = rt;
            OP_LUI: begin
                dest    = rt;
                uses_rs = 1'b0;
            end
            default: begin
                if (is_load_op(op)) begin
                    dest    = rt;
                    is_load = 1'b1;
                end else if (is_store_op(op)) begin
                    uses_rt = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
        // An unrecognised word travels as a pure bubble: no dest, no sources.
        if (illegal) begin
            dest    = 5'd0;
            is_load = 1'b0;
            lohi_wr = 1'b0;
            lohi_rd = 1'b0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
        end
    end

endmodule

// File: rtl/write_dest_tracker.sv
// Tracks in-flight destinations from issue to writeback, stalls issue on RAW
// and LO/HI hazards, and times the multi-cycle MULT busy window.
module write_dest_tracker
    import write_dest_tracker_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int MULT_LAT = 4,
    parameter int FWD      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [31:0] instruction,
    input  logic        flush,
    output logic        stall,
    output logic        illegal,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic        lohi_busy,
    output logic        lohi_done
);
    localparam int STAGE_W   = 7;
    localparam int E_LOAD    = 0;
    localparam int E_DEST_LO = 1;
    localparam int E_DEST_HI = 5;
    localparam int E_VALID   = 6;

    // With forwarding only a load in stage 0 can hurt; without it every stage
    // but the one writing back this cycle (write-first register file).
    localparam logic [DEPTH-1:0] HAZ_MASK = (FWD != 0) ? DEPTH'(1)
                                                       : DEPTH'((1 << (DEPTH - 1)) - 1);

    logic [DEPTH-1:0][STAGE_W-1:0] stage;
    logic [STAGE_W-1:0]            new_entry;
    logic [DEPTH-1:0]              hit;
    logic [4:0]                    dest, rs, rt;
    logic                          is_load, lohi_wr, lohi_rd, uses_rs, uses_rt, dec_illegal;
    logic                          hazard, lohi_stall, accept;
    logic [CNT_W-1:0]              lohi_cnt;
    logic                          unused_ins;

    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    assign unused_ins = ^{instruction[31:26], instruction[15:0]};

    dest_decode u_dec (
        .instruction (instruction),
        .dest        (dest),
        .is_load     (is_load),
        .lohi_wr     (lohi_wr),
        .lohi_rd     (lohi_rd),
        .uses_rs     (uses_rs),
        .uses_rt     (uses_rt),
        .illegal     (dec_illegal)
    );

    // Entries are only marked valid for a nonzero dest, so $0 never matches.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = stage[i][E_VALID] && (FWD == 0 || stage[i][E_LOAD]) &&
                     ((uses_rs && stage[i][E_DEST_HI:E_DEST_LO] == rs) ||
                      (uses_rt && stage[i][E_DEST_HI:E_DEST_LO] == rt));
        end
    end

    assign hazard     = |(hit & HAZ_MASK);
    assign lohi_stall = (lohi_wr || lohi_rd) && lohi_busy;
    assign stall      = issue_valid && (hazard || lohi_stall);
    assign illegal    = issue_valid && dec_illegal;
    assign accept     = issue_valid && !stall && !flush;
    assign new_entry  = accept ? {dest != 5'd0, dest, is_load} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage <= '0;
        end else if (flush) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], new_entry};
        end
    end

    assign wb_valid = stage[DEPTH-1][E_VALID];
    assign wb_reg   = stage[DEPTH-1][E_DEST_HI:E_DEST_LO];

    // Flush leaves the counter alone: an accepted MULT always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lohi_cnt  <= '0;
            lohi_busy <= 1'b0;
            lohi_done <= 1'b0;
        end else begin
            lohi_done <= 1'b0;
            if (accept && lohi_wr) begin
                lohi_cnt  <= CNT_W'(MULT_LAT);
                lohi_busy <= 1'b1;
            end else if (lohi_cnt != '0) begin
                lohi_cnt <= lohi_cnt - 1'b1;
                if (lohi_cnt == CNT_W'(1)) begin
                    lohi_busy <= 1'b0;
                    lohi_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_dest_tracker.sv
// Bench for write_dest_tracker: FWD=1 and FWD=0 instances share stimulus and are
// checked every cycle against a timestamp-based model of issue history.
module tb_write_dest_tracker;
    localparam int D = 3;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv, fl;
    logic [31:0] ins;
    logic        st0, st1, il0, il1, wv0, wv1, lb0, lb1, dn0, dn1;
    logic [4:0]  wr0, wr1;
    logic [1:0]  st_v, il_v, wv_v, lb_v, dn_v;
    logic [4:0]  wr_v [2];

    int ncmp = 0;
    int nfail = 0;

    // Model: what each DUT accepted at each cycle, last flush edge, last MULT accept.
    int         cyc, lf;
    bit         hv [2][16];
    logic [4:0] hd [2][16];
    bit         hl [2][16];
    int         mc [2];
    bit         st_obs [2];
    bit         dn_obs [2];
    int         ndone [2];
    int         nbusy [2];

    always #5 clk = ~clk;

    assign st_v = {st1, st0};
    assign il_v = {il1, il0};
    assign wv_v = {wv1, wv0};
    assign lb_v = {lb1, lb0};
    assign dn_v = {dn1, dn0};
    assign wr_v[0] = wr0;
    assign wr_v[1] = wr1;

    write_dest_tracker #(.DEPTH(D), .MULT_LAT(L), .FWD(1)) u_fwd (
        .clk(clk), .reset(reset), .issue_valid(iv), .instruction(ins), .flush(fl),
        .stall(st0), .illegal(il0), .wb_valid(wv0), .wb_reg(wr0),
        .lohi_busy(lb0), .lohi_done(dn0));

    write_dest_tracker #(.DEPTH(D), .MULT_LAT(L), .FWD(0)) u_nofwd (
        .clk(clk), .reset(reset), .issue_valid(iv), .instruction(ins), .flush(fl),
        .stall(st1), .illegal(il1), .wb_valid(wv1), .wb_reg(wr1),
        .lohi_busy(lb1), .lohi_done(dn1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtyp(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] ityp(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Reference decode straight from the ISA rules.
    function automatic void ref_dec(input logic [31:0] w, output logic [4:0] d,
                                    output bit ld, output bit lw, output bit lr,
                                    output bit urs, output bit urt, output bit ill);
        logic [5:0] op, fn;
        logic [4:0] rt, rd;
        op = w[31:26]; fn = w[5:0]; rt = w[20:16]; rd = w[15:11];
        d = 5'd0; ld = 0; lw = 0; lr = 0; urs = 1; urt = 0; ill = 0;
        if (op == 0) begin
            urt = 1;
            if (fn inside {0, 2, 3, 4, 6, 7, 9, 17, 19, 26, 27, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43})
                d = rd;
            else if (fn == 8) d = 5'd0;
            else if (fn inside {24, 25}) begin d = rd; lw = 1; end
            else if (fn inside {16, 18}) begin d = rd; lr = 1; end
            else ill = 1;
        end else if (op == 1) begin
            if (rt inside {16, 17}) d = 5'd31;
            else if (!(rt inside {0, 1})) ill = 1;
        end else if (op == 2) urs = 0;
        else if (op == 3) begin urs = 0; d = 5'd31; end
        else if (op inside {4, 5}) urt = 1;
        else if (op inside {6, 7}) d = 5'd0;
        else if (op inside {[8:14]}) d = rt;
        else if (op == 15) begin d = rt; urs = 0; end
        else if (op inside {[32:38]}) begin d = rt; ld = 1; end
        else if (op inside {40, 41, 42, 43, 46}) urt = 1;
        else ill = 1;
        if (ill) begin d = 5'd0; ld = 0; lw = 0; lr = 0; urs = 0; urt = 0; end
    endfunction

    // Is the instruction accepted (age) cycles ago still in flight?
    function automatic bit alive(input int k, input int age);
        int a;
        a = cyc - age;
        return a >= 1 && a > lf && hv[k][a % 16];
    endfunction

    function automatic logic [31:0] rnd_ins();
        int r, a, b, c;
        int fns [9] = '{32, 33, 34, 36, 37, 42, 0, 8, 9};
        int rts [4] = '{0, 1, 16, 17};
        int lhs [4] = '{24, 25, 16, 18};
        r = $urandom_range(0, 10);
        a = $urandom_range(0, 7); b = $urandom_range(0, 7); c = $urandom_range(0, 7);
        case (r)
            0, 1:    return rtyp(a, b, c, fns[$urandom_range(0, 8)]);
            2:       return ityp(8 + $urandom_range(0, 7), a, b, $urandom_range(0, 255));
            3:       return ityp($urandom_range(0, 1) ? 35 : 32, a, b, 4);
            4:       return ityp(43, a, b, 8);
            5:       return ityp(4 + $urandom_range(0, 1), a, b, 2);
            6:       return {6'(2 + $urandom_range(0, 1)), 26'($urandom)};
            7:       return ityp(1, a, rts[$urandom_range(0, 3)], 3);
            8, 9:    return rtyp(a, b, c, lhs[$urandom_range(0, 3)]);
            default: return $urandom_range(0, 1) ? {6'h3f, 26'($urandom)} : rtyp(a, b, c, 63);
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1; iv = 1'b0; fl = 1'b0; ins = 32'd0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_wbv[%0d]", k), 32'(wv_v[k]), 0);
            chk($sformatf("rst_wbr[%0d]", k), 32'(wr_v[k]), 0);
            chk($sformatf("rst_busy[%0d]", k), 32'(lb_v[k]), 0);
            chk($sformatf("rst_done[%0d]", k), 32'(dn_v[k]), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cyc = 0; lf = 0;
        for (int k = 0; k < 2; k++) begin
            mc[k] = -100; ndone[k] = 0; nbusy[k] = 0;
            for (int j = 0; j < 16; j++) hv[k][j] = 0;
        end
    endtask

    // One cycle: drive, check both DUTs mid-cycle against the model, advance the model.
    task automatic step(input bit v, input logic [31:0] w, input bit f);
        logic [4:0] d, rs, rt, xwr;
        bit ld, lw, lr, urs, urt, ill, haz, busy, done, xst;
        bit acc [2];
        int e;
        iv = v; ins = w; fl = f;
        ref_dec(w, d, ld, lw, lr, urs, urt, ill);
        rs = w[25:21]; rt = w[20:16];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            haz = 0;
            for (int age = 0; age < D - 1; age++) begin
                e = (cyc - age) % 16;
                if (alive(k, age) && ((urs && rs == hd[k][e]) || (urt && rt == hd[k][e])))
                    if (k == 1 || (age == 0 && hl[k][e])) haz = 1;
            end
            busy = cyc >= mc[k] && cyc < mc[k] + L;
            done = cyc == mc[k] + L;
            xst  = v && (haz || ((lw || lr) && busy));
            xwr  = alive(k, D - 1) ? hd[k][(cyc - D + 1) % 16] : 5'd0;
            acc[k] = v && !xst && !f;
            chk($sformatf("stall[%0d]@%0d", k, cyc), 32'(st_v[k]), 32'(xst));
            chk($sformatf("illegal[%0d]@%0d", k, cyc), 32'(il_v[k]), 32'(v && ill));
            chk($sformatf("wbv[%0d]@%0d", k, cyc), 32'(wv_v[k]), 32'(xwr != 0));
            chk($sformatf("wbr[%0d]@%0d", k, cyc), 32'(wr_v[k]), 32'(xwr));
            chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(lb_v[k]), 32'(busy));
            chk($sformatf("done[%0d]@%0d", k, cyc), 32'(dn_v[k]), 32'(done));
            st_obs[k] = st_v[k];
            dn_obs[k] = dn_v[k];
            ndone[k] += 32'(dn_v[k]);
            nbusy[k] += 32'(lb_v[k]);
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            hv[k][cyc % 16] = acc[k] && d != 0;
            hd[k][cyc % 16] = d;
            hl[k][cyc % 16] = ld;
            if (acc[k] && lw) mc[k] = cyc;
        end
        if (f) lf = cyc;
        #1;
    endtask

    // Present w until DUT k stops stalling; returns observed stall cycles.
    task automatic hold(input logic [31:0] w, input int k, output int nst, output bit dn_acc);
        bit took;
        nst = 0; dn_acc = 0; took = 0;
        for (int i = 0; i < 20 && !took; i++) begin
            step(1, w, 0);
            if (!st_obs[k]) begin
                took = 1;
                dn_acc = dn_obs[k];
            end else begin
                nst++;
            end
        end
        if (!took) nst = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  da;

        // ADDI $5,$0,1 reaches writeback after DEPTH edges
        do_reset();
        step(1, ityp(8, 0, 5, 1), 0);
        step(0, 32'd0, 0);
        step(0, 32'd0, 0);
        chk("addi_wbv", 32'(wv0), 1);
        chk("addi_wbr", 32'(wr0), 5);
        chk("addi_wbr_nf", 32'(wr1), 5);

        // LW $8 then ADD $9,$8,$1: one load-use stall with forwarding
        do_reset();
        step(1, ityp(35, 1, 8, 0), 0);
        hold(rtyp(8, 1, 9, 32), 0, n, da);
        chk("loaduse_stalls", n, 1);
        chk("lw_wbr", 32'(wr0), 8);
        step(0, 32'd0, 0);
        chk("bubble_wbv", 32'(wv0), 0);
        step(0, 32'd0, 0);
        chk("add_wbr", 32'(wr0), 9);
        step(0, 32'd0, 0);

        // ADD $3 then SUB $4,$3,$3 without forwarding: DEPTH-1 stalls
        do_reset();
        step(1, rtyp(1, 2, 3, 32), 0);
        hold(rtyp(3, 3, 4, 34), 1, n, da);
        chk("nofwd_stalls", n, 2);
        for (int i = 0; i < 3; i++) step(0, 32'd0, 0);

        // MULT, gap, MFLO: busy for MULT_LAT cycles, MFLO taken on the done pulse
        do_reset();
        step(1, rtyp(1, 2, 0, 24), 0);
        step(0, 32'd0, 0);
        hold(rtyp(0, 0, 7, 18), 0, n, da);
        chk("mflo_stalls", n, 3);
        chk("mflo_on_done", 32'(da), 1);
        for (int i = 0; i < 4; i++) step(0, 32'd0, 0);
        chk("done_pulses", ndone[0], 1);
        chk("busy_cycles", nbusy[0], L);

        // Destination classes
        do_reset();
        step(1, {6'd3, 26'h40}, 0); step(0, 32'd0, 0); step(0, 32'd0, 0);
        chk("jal_wbr", 32'(wr0), 31);
        step(1, ityp(1, 4, 17, 8), 0); step(0, 32'd0, 0); step(0, 32'd0, 0);
        chk("bgezal_wbr", 32'(wr0), 31);
        step(1, ityp(43, 29, 5, 0), 0); step(0, 32'd0, 0); step(0, 32'd0, 0);
        chk("sw_wbv", 32'(wv0), 0);
        step(1, ityp(4, 1, 2, 4), 0); step(0, 32'd0, 0); step(0, 32'd0, 0);
        chk("beq_wbv", 32'(wv0), 0);
        iv = 1'b1; ins = {6'h3f, 26'h123}; #1;
        chk("illegal_flag", 32'(il0), 1);
        step(1, {6'h3f, 26'h123}, 0); step(0, 32'd0, 0); step(0, 32'd0, 0);
        chk("illegal_wbv", 32'(wv0), 0);

        // Flush with dependent ADD presented: not accepted, pipe empty next cycle
        do_reset();
        step(1, ityp(35, 1, 2, 0), 0);
        iv = 1'b1; fl = 1'b1; ins = rtyp(2, 1, 3, 32); #1;
        chk("flush_dep_stall", 32'(st0), 1);
        step(1, rtyp(2, 1, 3, 32), 1);
        iv = 1'b1; fl = 1'b0; #1;
        chk("post_flush_stall", 32'(st0), 0);
        chk("post_flush_stall_nf", 32'(st1), 0);
        step(1, rtyp(2, 1, 3, 32), 0);
        step(0, 32'd0, 0); step(0, 32'd0, 0);
        chk("post_flush_wbr", 32'(wr0), 3);

        // Reset in the middle of traffic clears everything at once
        do_reset();
        step(1, rtyp(1, 2, 0, 25), 0);
        step(1, ityp(9, 0, 6, 1), 0);
        step(1, ityp(9, 0, 7, 1), 0);
        chk("pre_reset_busy", 32'(lb0), 1);
        chk("pre_reset_wbr", 32'(wr0), 0);
        do_reset();
        step(0, 32'd0, 0);

        // Randomised traffic, both DUTs against the model
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 8, rnd_ins(), $urandom_range(0, 24) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
